// File: rtl/sensor_scan_pkg.sv
// Shared types and helpers for the sensor chain scanner.
package sensor_scan_pkg;

  localparam int unsigned DEFAULT_NUM_BITS = 32;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    LOAD     = 3'd1,
    SETTLE   = 3'd2,
    SAMPLE   = 3'd3,
    SHIFT_HI = 3'd4,
    SHIFT_LO = 3'd5,
    COMPARE  = 3'd6,
    GAP      = 3'd7
  } scan_state_t;

  // Bits needed to hold values 0..max_val (at least one bit).
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/sensor_scan_controller_if.sv
// Publish/acknowledge path between the scanner and the memory-mapped I/O manager.
interface sensor_scan_controller_if
  import sensor_scan_pkg::*;
#(
  parameter int unsigned NUM_BITS = DEFAULT_NUM_BITS
);
  logic [NUM_BITS-1:0] board_out;
  logic                change_pending;
  logic                change_ack;
  logic                overrun;

  modport master (output board_out, change_pending, overrun, input change_ack);
  modport slave  (input board_out, change_pending, overrun, output change_ack);
endinterface

// File: rtl/scan_debouncer.sv
// Debounces successive scan words and publishes a stable board with a pending/ack handshake.
module scan_debouncer
  import sensor_scan_pkg::*;
#(
  parameter int unsigned NUM_BITS     = DEFAULT_NUM_BITS,
  parameter int unsigned STABLE_SCANS = 4
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [NUM_BITS-1:0] scan_word,
  input  logic                compare,
  input  logic                change_ack,
  output logic [NUM_BITS-1:0] board_out,
  output logic                change_pending,
  output logic                overrun
);

  localparam int unsigned     SW         = cnt_width(STABLE_SCANS);
  localparam logic [SW-1:0]   STABLE_MAX = SW'(STABLE_SCANS);

  logic [NUM_BITS-1:0] candidate;
  logic [SW-1:0]       stable_cnt;
  logic [SW-1:0]       next_cnt;
  logic                publish;

  always_comb begin
    next_cnt = SW'(1);
    if (scan_word == candidate)
      next_cnt = (stable_cnt == STABLE_MAX) ? STABLE_MAX : stable_cnt + SW'(1);
    publish = compare && (next_cnt == STABLE_MAX) && (scan_word != board_out);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      candidate      <= '0;
      stable_cnt     <= '0;
      board_out      <= '0;
      change_pending <= 1'b0;
      overrun        <= 1'b0;
    end else begin
      if (compare) begin
        candidate  <= scan_word;
        stable_cnt <= next_cnt;
      end
      if (publish)
        board_out <= scan_word;
      // A publish beats a same-cycle ack; that ack still consumes the old board, so no overrun.
      if (publish)
        change_pending <= 1'b1;
      else if (change_ack)
        change_pending <= 1'b0;
      if (publish && change_pending && !change_ack)
        overrun <= 1'b1;
      else if (change_ack)
        overrun <= 1'b0;
    end
  end

endmodule

// File: rtl/sensor_scan_controller.sv
// Sequences the sensor shift-register chain (load, settle, serial shift) and feeds the debouncer.
module sensor_scan_controller
  import sensor_scan_pkg::*;
#(
  parameter int unsigned CLK_DIV      = 50,
  parameter int unsigned NUM_BITS     = DEFAULT_NUM_BITS,
  parameter int unsigned STABLE_SCANS = 4,
  parameter int unsigned GAP_CYCLES   = 1000
) (
  input  logic clock,
  input  logic reset,
  input  logic enable,
  input  logic in_val,
  output logic sr_clk,
  output logic parallel_mode,
  output logic busy,
  output logic scan_done,
  sensor_scan_controller_if.master bus
);

  localparam int unsigned   TW       = cnt_width((CLK_DIV > GAP_CYCLES) ? CLK_DIV : GAP_CYCLES);
  localparam int unsigned   BW       = cnt_width(NUM_BITS);
  localparam logic [TW-1:0] DIV_LAST = TW'(CLK_DIV - 1);
  localparam logic [TW-1:0] GAP_LAST = TW'(GAP_CYCLES - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(NUM_BITS - 1);

  scan_state_t         state;
  logic [TW-1:0]       tick;
  logic [BW-1:0]       bit_idx;
  logic [NUM_BITS-1:0] shift_q;
  logic [NUM_BITS-1:0] board_q;
  logic                pending_q;
  logic                overrun_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= IDLE;
      tick          <= '0;
      bit_idx       <= '0;
      shift_q       <= '0;
      sr_clk        <= 1'b0;
      parallel_mode <= 1'b1;
    end else begin
      case (state)
        IDLE: begin
          if (enable) begin
            state         <= LOAD;
            parallel_mode <= 1'b0;
            tick          <= '0;
          end
        end
        LOAD: begin
          if (tick == DIV_LAST) begin
            state         <= SETTLE;
            parallel_mode <= 1'b1;
            tick          <= '0;
          end else tick <= tick + TW'(1);
        end
        SETTLE: begin
          if (tick == DIV_LAST) begin
            state   <= SAMPLE;
            tick    <= '0;
            bit_idx <= '0;
          end else tick <= tick + TW'(1);
        end
        SAMPLE: begin
          // MSB-first left shift lands sample k at bit NUM_BITS-1-k once all bits are in.
          shift_q <= {shift_q[NUM_BITS-2:0], in_val};
          tick    <= '0;
          if (bit_idx == BIT_LAST) state <= COMPARE;
          else begin
            state  <= SHIFT_HI;
            sr_clk <= 1'b1;
          end
        end
        SHIFT_HI: begin
          if (tick == DIV_LAST) begin
            state  <= SHIFT_LO;
            sr_clk <= 1'b0;
            tick   <= '0;
          end else tick <= tick + TW'(1);
        end
        SHIFT_LO: begin
          if (tick == DIV_LAST) begin
            state   <= SAMPLE;
            bit_idx <= bit_idx + BW'(1);
            tick    <= '0;
          end else tick <= tick + TW'(1);
        end
        COMPARE: begin
          state <= GAP;
          tick  <= '0;
        end
        GAP: begin
          if (tick == GAP_LAST) begin
            tick <= '0;
            if (enable) begin
              state         <= LOAD;
              parallel_mode <= 1'b0;
            end else state <= IDLE;
          end else tick <= tick + TW'(1);
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign busy      = (state != IDLE) && (state != GAP);
  assign scan_done = (state == COMPARE);

  scan_debouncer #(
    .NUM_BITS    (NUM_BITS),
    .STABLE_SCANS(STABLE_SCANS)
  ) u_debouncer (
    .clock         (clock),
    .reset         (reset),
    .scan_word     (shift_q),
    .compare       (scan_done),
    .change_ack    (bus.change_ack),
    .board_out     (board_q),
    .change_pending(pending_q),
    .overrun       (overrun_q)
  );

  assign bus.board_out      = board_q;
  assign bus.change_pending = pending_q;
  assign bus.overrun        = overrun_q;

endmodule

// File: doc/sensor_scan_controller.md
Name: sensor_scan_controller

Overview:
- Sequences the checkerboard sensor shift-register chain: parallel load, then serial shift of NUM_BITS occupancy bits.
- Debounces successive scans and publishes a stable board word to the memory-mapped I/O manager.
- Uses a pending/ack handshake so software sees each board change exactly once.
- Sits between the external sensor pins and the memory manager's sensor input register.

Parameters:
- CLK_DIV, 50: system cycles per shift-clock half period, and per load/settle phase; must be >= 1.
- NUM_BITS, 32: number of sensor bits in the chain.
- STABLE_SCANS, 4: identical consecutive scans required before publishing; must be >= 1.
- GAP_CYCLES, 1000: idle cycles between scans.

Ports:
- clock  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- enable  in  1  scanning enabled.
- in_val  in  1  serial data from chain.
- sr_clk  out  1  shift clock to chain.
- parallel_mode  out  1  0 = parallel load, 1 = shift.
- board_out  out  NUM_BITS  last published stable board.
- change_pending  out  1  new board published, not yet acknowledged.
- change_ack  in  1  single-cycle acknowledge from the memory manager.
- overrun  out  1  sticky: a publish occurred while change_pending was already 1.
- busy  out  1  high from LOAD entry through COMPARE.
- scan_done  out  1  one-cycle pulse in COMPARE.

Behaviour:
- Reset values (asynchronous, active-high): sr_clk=0, parallel_mode=1, board_out=0, change_pending=0, overrun=0, busy=0, scan_done=0. State=IDLE, candidate=0, stable_cnt=0, tick and bit counters 0.
- Reset mid-scan abandons the scan; the first scan after release starts from LOAD.
- States:
  - IDLE: if enable, go to LOAD.
  - LOAD: parallel_mode=0 for CLK_DIV cycles; then parallel_mode=1, go to SETTLE.
  - SETTLE: CLK_DIV cycles, then SAMPLE.
  - SAMPLE: 1 cycle. Capture in_val into shift[NUM_BITS-1-k], where k is the sample index starting at 0. If k==NUM_BITS-1, go to COMPARE; else go to SHIFT_HI.
  - SHIFT_HI: sr_clk=1 for CLK_DIV cycles.
  - SHIFT_LO: sr_clk=0 for CLK_DIV cycles, then SAMPLE.
  - COMPARE: 1 cycle, scan_done=1, debounce update. Go to GAP.
  - GAP: GAP_CYCLES cycles. Then go to LOAD if enable, else IDLE.
- Pulse count: exactly NUM_BITS-1 sr_clk rising edges per scan.
- sr_clk and parallel_mode are registered outputs and must not glitch.
- Enable deassert mid-scan: the current scan completes, including COMPARE and GAP, then the block goes to IDLE.
- Debounce, evaluated in COMPARE:
  - If shift==candidate: stable_cnt = min(stable_cnt+1, STABLE_SCANS).
  - Else: candidate=shift, stable_cnt=1.
  - Publish when the resulting stable_cnt==STABLE_SCANS and candidate!=board_out: board_out<=candidate, change_pending<=1.
  - With STABLE_SCANS=1, every differing scan publishes.
  - A board equal to board_out never republishes.
- Handshake:
  - change_ack clears change_pending and overrun on the next edge.
  - Publish while change_pending=1 and no ack in the same cycle: overrun<=1, board_out still updates.
  - Publish coincident with ack: change_pending stays 1 (set wins), overrun is not set.
  - Ack while change_pending=0 has no effect.
- Scan period = 2*CLK_DIV + NUM_BITS + 2*CLK_DIV*(NUM_BITS-1) + 1 + GAP_CYCLES cycles.

Decomposition:
- Package sensor_scan_pkg holds:
  - State enumeration: IDLE, LOAD, SETTLE, SAMPLE, SHIFT_HI, SHIFT_LO, COMPARE, GAP.
  - Default board width constant, 32.
  - Counter width derivation function (clog2-based).
- Sub-module scan_debouncer owns candidate, stable_cnt, board_out, change_pending and overrun.
  - Inputs: scan word and a compare strobe.
  - Keeps the pin sequencer and the publish logic separately verifiable.

Test Plan (use CLK_DIV=2, GAP_CYCLES=4, STABLE_SCANS=3, NUM_BITS=32, with a bench model of the chain that loads on parallel_mode=0 and shifts MSB-first on sr_clk rising edges):
- Reset mid-SHIFT_HI with sr_clk=1 -> all outputs at reset values within the same cycle; first post-reset scan begins with a LOAD phase of exactly 2 cycles.
- Constant chain 0xA5A50F0F, enable=1 -> 31 sr_clk rising edges per scan. board_out=0xA5A50F0F and change_pending=1 one edge after the 3rd scan_done; unchanged before it.
- Stable 0xA5A50F0F published and acked, then one scan of 0xFFFFFFFF, then back to 0xA5A50F0F -> board_out stays 0xA5A50F0F and change_pending never rises again.
- Publish 0x00000001 with no ack, then publish 0x00000003 -> overrun=1 and board_out=0x00000003. Ack -> change_pending=0 and overrun=0. Ack coincident with a publish -> change_pending=1, overrun=0.
- enable dropped during sample 10 -> the scan finishes, scan_done pulses once, then IDLE with busy=0 and no further sr_clk edges.
- STABLE_SCANS=1 build, chain alternating 0x1 and 0x2 every scan -> publish on every scan; overrun=1 after the 2nd scan without ack.
